// File: rtl/joydb_serial_reader.sv
// Reading end of the DB9/JAMMA 74HC165 joystick chain: drives joy_load/joy_clk, shifts in joy_data
// and presents two active-high player words with a one-cycle frame_valid strobe.
module joydb_serial_reader #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned NBITS     = 24,
    parameter int unsigned GAP_TICKS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               joy_data,
    output logic               joy_clk,
    output logic               joy_load,
    output logic [NBITS/2-1:0] joy1,
    output logic [NBITS/2-1:0] joy2,
    output logic               frame_valid,
    output logic               busy
);

    localparam int unsigned HALF  = NBITS / 2;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
    localparam int unsigned BIT_W = $clog2(NBITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_TICKS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               phase_q, phase_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [1:0]         sync_q;
    logic [HALF-1:0]    joy1_q, joy1_d;
    logic [HALF-1:0]    joy2_q, joy2_d;
    logic               valid_q, valid_d;
    logic               joy_clk_q, joy_load_q, busy_q;
    logic               tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            sync_q <= '0;
        end else begin
            div_q  <= tick ? '0 : div_q + 1'b1;
            sync_q <= {sync_q[0], joy_data};
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (gap_q == GAP_MAX) begin
                        if (enable) begin
                            gap_d   = '0;
                            state_d = StLoad;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                if (tick) begin
                    state_d = StShift;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!phase_q) begin
                        // Sample before the rising edge: bit 0 is already on the line after load.
                        shift_d = {shift_q[NBITS-2:0], sync_q[1]};
                        phase_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = StDone;
                            joy1_d  = ~shift_q[NBITS-1:HALF];
                            joy2_d  = ~shift_q[HALF-1:0];
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                gap_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin drivers come straight from flops fed by the next state, so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            joy1_q     <= '0;
            joy2_q     <= '0;
            valid_q    <= 1'b0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            valid_q    <= valid_d;
            joy_clk_q  <= (state_d == StShift) && phase_d;
            joy_load_q <= (state_d != StLoad);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign joy_clk     = joy_clk_q;
    assign joy_load    = joy_load_q;
    assign joy1        = joy1_q;
    assign joy2        = joy2_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_joydb_serial_reader.sv
// Bench for joydb_serial_reader: 74HC165 chain model, frame-schedule reference model checked
// every cycle, directed timing/data cases and a randomized enable/reset/pattern run.
module tb_joydb_serial_reader;

    localparam int CLK_DIV   = 4;
    localparam int NBITS     = 24;
    localparam int GAP_TICKS = 2;
    localparam int HALF      = NBITS / 2;
    localparam int DONE_OFF  = CLK_DIV * (1 + 2 * NBITS);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             joy_data;
    logic             joy_clk, joy_load, frame_valid, busy;
    logic [HALF-1:0]  joy1, joy2;
    logic [NBITS-1:0] pattern = '0;
    logic [NBITS-1:0] chain;
    logic             clk_prev;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    joydb_serial_reader #(
        .CLK_DIV   (CLK_DIV),
        .NBITS     (NBITS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .joy_data    (joy_data),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joy1        (joy1),
        .joy2        (joy2),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    // Shift-register chain: parallel load while joy_load is low, shift on joy_clk rising edge.
    always @(posedge clk) begin
        if (reset) chain <= '0;
        else if (joy_load === 1'b0) chain <= pattern;
        else if (joy_clk === 1'b1 && clk_prev == 1'b0) chain <= {chain[NBITS-2:0], 1'b1};
        clk_prev <= (joy_clk === 1'b1);
    end
    assign joy_data = chain[NBITS-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    endtask

    // Inputs as seen by the DUT on each active edge.
    logic             s_reset, s_en;
    logic [NBITS-1:0] s_pat;
    always @(posedge clk) begin
        s_reset <= reset;
        s_en    <= enable;
        s_pat   <= pattern;
    end

    // Reference model: a frame is a fixed schedule of cycles after its start; frames start on
    // the first tick in idle where at least GAP_TICKS ticks have elapsed and enable is high.
    bit               m_valid = 1'b0;
    bit               m_in_frame;
    int               m_cyc, m_fs, m_idle, m_t;
    logic [NBITS-1:0] m_pat;
    logic [HALF-1:0]  m_j1, m_j2;
    logic             e_load, e_clk, e_busy, e_fv;

    initial begin
        forever begin
            @(negedge clk);
            if (s_reset === 1'b1) begin
                m_valid    = 1'b1;
                m_cyc      = 0;
                m_in_frame = 1'b0;
                m_idle     = 0;
                m_j1       = '0;
                m_j2       = '0;
            end else if (m_valid) begin
                if (!m_in_frame) begin
                    if (m_cyc % CLK_DIV == CLK_DIV - 1) begin
                        if (m_idle >= GAP_TICKS && s_en === 1'b1) begin
                            m_in_frame = 1'b1;
                            m_fs       = m_cyc + 1;
                            m_pat      = s_pat;
                        end else begin
                            m_idle++;
                        end
                    end
                end else if (m_cyc == m_fs + DONE_OFF) begin
                    m_in_frame = 1'b0;
                    m_idle     = 0;
                end
                m_cyc++;
                if (m_in_frame && m_cyc == m_fs + DONE_OFF) begin
                    m_j1 = ~m_pat[NBITS-1:HALF];
                    m_j2 = ~m_pat[HALF-1:0];
                end
            end
            if (m_valid) begin
                e_load = 1'b1; e_clk = 1'b0; e_busy = 1'b0; e_fv = 1'b0;
                if (m_in_frame) begin
                    m_t    = m_cyc - m_fs;
                    e_busy = 1'b1;
                    e_load = (m_t >= CLK_DIV);
                    e_fv   = (m_t == DONE_OFF);
                    e_clk  = (m_t >= CLK_DIV) && (m_t < DONE_OFF) &&
                             (((m_t - CLK_DIV) / CLK_DIV) % 2 == 1);
                end
                check("cycle_outputs{load,clk,busy,fv,joy1,joy2}",
                      {4'h0, joy_load, joy_clk, busy, frame_valid, joy1, joy2},
                      {4'h0, e_load, e_clk, e_busy, e_fv, m_j1, m_j2});
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_fv(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_static(input logic [NBITS-1:0] p, input logic [HALF-1:0] exp, input string nm);
        bit ok;
        pattern = p;
        do_reset(2);
        wait_fv(600, ok);
        check({nm, "_fv_seen"}, ok, 1);
        check({nm, "_joy1"}, joy1, exp);
        check({nm, "_joy2"}, joy2, exp);
    endtask

    int first_load, load_cnt, pulses, bad_w, w, fv1, fv2, act, ld, fv_cnt, late_loads, fv_at;
    logic [HALF-1:0] a_j1, a_j2;
    bit seen_fv, ok;

    initial begin
        // Timing and data after reset release.
        pattern = 24'h0F0A5C;
        enable  = 1'b1;
        @(negedge clk);
        do_reset(3);
        first_load = -1; load_cnt = 0; pulses = 0; bad_w = 0; w = 0; fv1 = -1; fv2 = -1;
        for (int i = 1; i <= 430; i++) begin
            @(negedge clk);
            if (joy_load === 1'b0 && i <= 210) begin
                load_cnt++;
                if (first_load < 0) first_load = i;
            end
            if (joy_clk === 1'b1) w++;
            else if (w != 0) begin
                if (i <= 210) pulses++;
                if (w != 4) bad_w++;
                w = 0;
            end
            if (frame_valid === 1'b1) begin
                if (fv1 < 0) begin fv1 = i; a_j1 = joy1; a_j2 = joy2; end
                else if (fv2 < 0) fv2 = i;
            end
        end
        check("first_load_cycle", first_load, 12);
        check("load_low_cycles", load_cnt, 4);
        check("joy_clk_pulses", pulses, 24);
        check("bad_pulse_widths", bad_w, 0);
        check("first_fv_cycle", fv1, 208);
        check("second_fv_cycle", fv2, 416);
        check("chain_joy1", a_j1, 12'hF0F);
        check("chain_joy2", a_j2, 12'h5A3);

        // Static data line.
        run_static(24'h000000, 12'hFFF, "static_low");
        run_static(24'hFFFFFF, 12'h000, "static_high");

        // enable low from reset, then raised at cycle 1001.
        enable  = 1'b0;
        pattern = 24'h123456;
        do_reset(2);
        act = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (joy_load !== 1'b1 || joy_clk !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0)
                act++;
        end
        check("idle_activity", act, 0);
        @(negedge clk);
        enable = 1'b1;
        ld = -1;
        for (int k = 1002; k <= 1040; k++) begin
            @(negedge clk);
            if (joy_load === 1'b0 && ld < 0) ld = k;
        end
        check("load_after_enable", ld, 1004);

        // Drop enable mid-shift: frame completes once, then no further load.
        enable = 1'b0;
        fv_cnt = 0; late_loads = 0; seen_fv = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                fv_cnt++;
                seen_fv = 1'b1;
                a_j1 = joy1;
                a_j2 = joy2;
            end else if (seen_fv && joy_load === 1'b0) late_loads++;
        end
        check("disable_fv_count", fv_cnt, 1);
        check("disable_late_loads", late_loads, 0);
        check("disable_joy1", a_j1, 12'hEDC);
        check("disable_joy2", a_j2, 12'hBA9);

        // Reset pulse mid-shift.
        pattern = 24'hABCDEF;
        enable  = 1'b1;
        ld = 0;
        for (int i = 0; i < 60 && ld == 0; i++) begin
            @(negedge clk);
            if (joy_load === 1'b0) ld = 1;
        end
        check("abort_load_seen", ld, 1);
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_joy_clk", joy_clk, 0);
        check("abort_joy_load", joy_load, 1);
        check("abort_joy1", joy1, 0);
        check("abort_joy2", joy2, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        fv_cnt = 0; fv_at = -1;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                fv_cnt++;
                if (fv_at < 0) begin fv_at = i; a_j1 = joy1; a_j2 = joy2; end
            end
        end
        check("abort_fv_count", fv_cnt, 1);
        check("abort_fv_cycle", fv_at, 208);
        check("abort_joy1_after", a_j1, 12'h543);
        check("abort_joy2_after", a_j2, 12'h210);

        // Randomized enable, pattern and reset activity against the reference model.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            if (frame_valid === 1'b1) begin
                case ($urandom_range(0, 3))
                    0:       pattern = '0;
                    1:       pattern = '1;
                    default: pattern = NBITS'($urandom);
                endcase
            end
            if ($urandom_range(0, 59) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1499) == 0) begin
                reset   = 1'b1;
                pattern = NBITS'($urandom);
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
